// File: rtl/bus_master_arbiter_pkg.sv
// Shared widths, encodings and helpers for the four-master system bus arbiter.
// Bus levels follow the legacy active-low naming: ENABLE_/DISABLE_ are strobe levels.
package bus_master_arbiter_pkg;

    localparam int WORD_ADDR_W = 30;
    localparam int WORD_DATA_W = 32;
    localparam int NUM_MASTERS = 4;
    localparam int OWNER_W     = 2;

    localparam logic READ     = 1'b1;
    localparam logic WRITE    = 1'b0;
    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    localparam logic [0:0] ARB_IDLE  = 1'b0;
    localparam logic [0:0] ARB_GRANT = 1'b1;

    typedef logic [OWNER_W-1:0] owner_t;

    typedef struct packed {
        logic [WORD_ADDR_W-1:0] addr;
        logic                   as_n;
        logic                   rw;
        logic [WORD_DATA_W-1:0] wr_data;
    } bus_cycle_t;

    function automatic logic [NUM_MASTERS-1:0] onehot(input owner_t idx);
        logic [NUM_MASTERS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/bus_master_arbiter_if.sv
// Master-side request/bus bundle and the shared-bus outputs of the arbiter.
// The slave modport is the arbiter's view; the master modport is the masters' view.
interface bus_master_arbiter_if;
    import bus_master_arbiter_pkg::*;

    logic [NUM_MASTERS-1:0]             mReq_;
    logic [NUM_MASTERS*WORD_ADDR_W-1:0] mAddr;
    logic [NUM_MASTERS-1:0]             mAs_;
    logic [NUM_MASTERS-1:0]             mRw;
    logic [NUM_MASTERS*WORD_DATA_W-1:0] mWrData;
    logic [NUM_MASTERS-1:0]             mGrnt_;
    logic [WORD_ADDR_W-1:0]             sAddr;
    logic                               sAs_;
    logic                               sRw;
    logic [WORD_DATA_W-1:0]             sWrData;
    logic [OWNER_W-1:0]                 owner;
    logic                               busy;

    modport master (
        output mReq_, mAddr, mAs_, mRw, mWrData,
        input  mGrnt_, sAddr, sAs_, sRw, sWrData, owner, busy
    );

    modport slave (
        input  mReq_, mAddr, mAs_, mRw, mWrData,
        output mGrnt_, sAddr, sAs_, sRw, sWrData, owner, busy
    );

endinterface

// File: rtl/bus_master_arbiter_rr_pick4.sv
// Combinational round-robin picker: first set request scanning from last+1 modulo 4.
// The last owner itself is considered only after all other masters.
module rr_pick4
    import bus_master_arbiter_pkg::*;
(
    input  logic [NUM_MASTERS-1:0] req,
    input  owner_t                 last,
    output owner_t                 idx,
    output logic                   found
);

    owner_t cand;

    // Walk from farthest to nearest so the nearest requester overwrites the result.
    always_comb begin
        idx   = last;
        found = 1'b0;
        cand  = last;
        for (int k = NUM_MASTERS; k >= 1; k--) begin
            cand = last + owner_t'(k);
            if (req[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_master_arbiter.sv
// Round-robin owner of the shared system bus for four masters; ARB_HOLD_LIMIT_EN adds forced rotation.
// Grants are registered (1 cycle after request, no dead cycle on handover); the owner keeps the bus until release.
module bus_master_arbiter
    import bus_master_arbiter_pkg::*;
#(
    parameter int HOLD_MAX   = 16,
    parameter int HOLD_CNT_W = 5
) (
    input  logic                clk,
    input  logic                reset,
    bus_master_arbiter_if.slave bus
);

    logic [0:0]             state_q;
    logic [0:0]             state_d;
    owner_t                 owner_q;
    owner_t                 owner_d;
    logic [NUM_MASTERS-1:0] grnt_q;
    logic [NUM_MASTERS-1:0] grnt_d;
    logic                   busy_q;
    logic [NUM_MASTERS-1:0] req;
    logic [NUM_MASTERS-1:0] others;
    logic [NUM_MASTERS-1:0] pick_req;
    owner_t                 pick_idx;
    logic                   pick_found;
    logic                   owner_rel;
    logic                   force_rot;
    bus_cycle_t             bus_out;

    if (2**HOLD_CNT_W <= HOLD_MAX) begin : g_bad_hold_cfg
        $error("HOLD_CNT_W is too narrow to reach HOLD_MAX");
    end

    assign req       = ~bus.mReq_;
    assign others    = req & ~onehot(owner_q);
    assign owner_rel = (bus.mReq_[owner_q] == DISABLE_);
    // While granted the current owner is excluded, so a re-request after release loses to waiters.
    assign pick_req  = (state_q == ARB_GRANT) ? others : req;

    rr_pick4 u_pick (
        .req   (pick_req),
        .last  (owner_q),
        .idx   (pick_idx),
        .found (pick_found)
    );

`ifdef ARB_HOLD_LIMIT_EN
    localparam logic [HOLD_CNT_W-1:0] HOLD_LIM = HOLD_CNT_W'(HOLD_MAX);

    logic [HOLD_CNT_W-1:0] hold_cnt_q;

    // Rotation is only forced between transactions, never under an active strobe.
    assign force_rot = (state_q == ARB_GRANT) && (hold_cnt_q >= HOLD_LIM) &&
                       (bus.mAs_[owner_q] == DISABLE_);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_cnt_q <= '0;
        end else if ((state_q != ARB_GRANT) || (state_d != ARB_GRANT) ||
                     (owner_d != owner_q) || (others == '0)) begin
            hold_cnt_q <= '0;
        end else if (hold_cnt_q < HOLD_LIM) begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
        end
    end
`else
    assign force_rot = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        grnt_d  = grnt_q;
        if (state_q == ARB_IDLE) begin
            if (pick_found) begin
                state_d = ARB_GRANT;
                owner_d = pick_idx;
                grnt_d  = ~onehot(pick_idx);
            end
        end else if (owner_rel || force_rot) begin
            if (pick_found) begin
                owner_d = pick_idx;
                grnt_d  = ~onehot(pick_idx);
            end else if (owner_rel) begin
                // owner is kept so the next scan still starts after the last user.
                state_d = ARB_IDLE;
                grnt_d  = '1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ARB_IDLE;
            owner_q <= owner_t'(NUM_MASTERS - 1);
            grnt_q  <= '1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            grnt_q  <= grnt_d;
            busy_q  <= ~&grnt_d;
        end
    end

    always_comb begin
        bus_out.addr    = '0;
        bus_out.as_n    = DISABLE_;
        bus_out.rw      = READ;
        bus_out.wr_data = '0;
        if (state_q == ARB_GRANT) begin
            bus_out.addr    = bus.mAddr[int'(owner_q)*WORD_ADDR_W +: WORD_ADDR_W];
            bus_out.as_n    = bus.mAs_[owner_q];
            bus_out.rw      = bus.mRw[owner_q];
            bus_out.wr_data = bus.mWrData[int'(owner_q)*WORD_DATA_W +: WORD_DATA_W];
        end
    end

    assign bus.mGrnt_  = grnt_q;
    assign bus.busy    = busy_q;
    assign bus.owner   = owner_q;
    assign bus.sAddr   = bus_out.addr;
    assign bus.sAs_    = bus_out.as_n;
    assign bus.sRw     = bus_out.rw;
    assign bus.sWrData = bus_out.wr_data;

    a_one_cold : assert property (@(posedge clk) disable iff (reset) $onehot0(~grnt_q));

endmodule

// File: tb/tb_bus_master_arbiter.sv
// Randomized and directed stimulus for bus_master_arbiter, checked against a queue-based reference model.
module tb_bus_master_arbiter;
    import bus_master_arbiter_pkg::*;

    localparam int HOLD_MAX   = 4;
    localparam int HOLD_CNT_W = 5;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bus_master_arbiter_if bif();

    bus_master_arbiter #(.HOLD_MAX(HOLD_MAX), .HOLD_CNT_W(HOLD_CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    typedef struct packed {
        logic [3:0]  grnt;
        logic        busy;
        logic [1:0]  owner;
        logic [29:0] addr;
        logic        as_n;
        logic        rw;
        logic [31:0] wd;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    exp_t mon_g;
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: holder = -1 when nobody holds the bus.
    int m_owner;
    int m_holder;
    int m_cnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int scan(input int from, input logic [3:0] r, input int skip);
        for (int k = 1; k <= 4; k++) begin
            int i;
            i = (from + k) % 4;
            if (i != skip && r[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner  = 3;
        m_holder = -1;
        m_cnt    = 0;
    endtask

    task automatic model_step();
        logic [3:0] r;
        int         n;
        int         h;
        bit         others;
        bit         rel;
        bit         frc;
        r = ~bif.mReq_;
        if (m_holder < 0) begin
            m_cnt = 0;
            n = scan(m_owner, r, -1);
            if (n >= 0) begin
                m_holder = n;
                m_owner  = n;
            end
        end else begin
            h      = m_holder;
            others = (r & ~(4'b0001 << h)) != 4'b0000;
            rel    = !r[h];
            frc    = 0;
`ifdef ARB_HOLD_LIMIT_EN
            frc = (m_cnt >= HOLD_MAX) && bif.mAs_[h];
`endif
            n = (rel || frc) ? scan(h, r, h) : -1;
            if (n >= 0) begin
                m_holder = n;
                m_owner  = n;
                m_cnt    = 0;
            end else if (rel) begin
                m_holder = -1;
                m_cnt    = 0;
            end else begin
                m_cnt = others ? ((m_cnt < HOLD_MAX) ? m_cnt + 1 : HOLD_MAX) : 0;
            end
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.owner = m_owner[1:0];
        if (m_holder < 0) begin
            e.grnt = 4'b1111;
            e.busy = 1'b0;
            e.addr = '0;
            e.as_n = 1'b1;
            e.rw   = 1'b1;
            e.wd   = '0;
        end else begin
            e.grnt = ~(4'b0001 << m_holder);
            e.busy = 1'b1;
            e.addr = bif.mAddr[m_holder*30 +: 30];
            e.as_n = bif.mAs_[m_holder];
            e.rw   = bif.mRw[m_holder];
            e.wd   = bif.mWrData[m_holder*32 +: 32];
        end
        return e;
    endfunction

    task automatic set_inputs(input logic [3:0] rq, input logic [3:0] as, input logic [3:0] rw);
        bif.mReq_ = rq;
        bif.mAs_  = as;
        bif.mRw   = rw;
        for (int i = 0; i < 4; i++) begin
            bif.mAddr[i*30 +: 30]   = 30'($urandom);
            bif.mWrData[i*32 +: 32] = $urandom;
        end
    endtask

    // Called at a negedge; returns at the following negedge with the post-edge state settled.
    task automatic drive(input logic [3:0] rq, input logic [3:0] as, input logic [3:0] rw);
        set_inputs(rq, as, rw);
        model_step();
        exp_q.push_back(model_out());
        @(negedge clk);
    endtask

    task automatic do_reset(input logic [3:0] rq);
        reset = 1'b1;
        set_inputs(rq, 4'b1111, 4'b1111);
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_grnt", bif.mGrnt_, 4'b1111);
        chk("rst_busy", bif.busy, 1'b0);
        chk("rst_owner", bif.owner, 2'd3);
        chk("rst_sas", bif.sAs_, 1'b1);
        chk("rst_srw", bif.sRw, 1'b1);
        chk("rst_saddr", bif.sAddr, 30'd0);
        reset = 1'b0;
    endtask

    // Scoreboard monitor: one expected record per clock edge driven by the stimulus.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                mon_g = {bif.mGrnt_, bif.busy, bif.owner, bif.sAddr, bif.sAs_, bif.sRw, bif.sWrData};
                n_tests++;
                if (mon_g !== mon_e) begin
                    n_fail++;
                    $display("FAIL scoreboard @%0t: got grnt=%b busy=%b own=%0d addr=%h as=%b rw=%b wd=%h, expected grnt=%b busy=%b own=%0d addr=%h as=%b rw=%b wd=%h",
                             $time, mon_g.grnt, mon_g.busy, mon_g.owner, mon_g.addr, mon_g.as_n, mon_g.rw, mon_g.wd,
                             mon_e.grnt, mon_e.busy, mon_e.owner, mon_e.addr, mon_e.as_n, mon_e.rw, mon_e.wd);
                end
                chk("one_cold", ($countones(~bif.mGrnt_) <= 1), 1'b1);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int         age;
        int         prev;
        int         gaps;
        int         obs[$];
        int         exp_order[5];
        int         bad;
        int         first_k;
        logic [3:0] rq;
        logic [3:0] as;

        reset = 1'b1;
        set_inputs(4'b1111, 4'b1111, 4'b1111);
        model_reset();
        @(negedge clk);

        // All request through reset: round-robin order with back-to-back handovers.
        do_reset(4'b0000);
        exp_order = '{0, 1, 2, 3, 0};
        age  = 0;
        gaps = 0;
        for (int c = 0; c < 18; c++) begin
            rq = 4'b0000;
            if (m_holder >= 0 && age == 2) rq[m_holder] = 1'b1;
            prev = m_holder;
            drive(rq, 4'b1111, 4'b1111);
            if (c == 0) begin
                chk("first_grnt", bif.mGrnt_, 4'b1110);
                chk("first_owner", bif.owner, 2'd0);
                chk("first_saddr", bif.sAddr, bif.mAddr[29:0]);
            end
            age = (m_holder != prev) ? 0 : age + 1;
            if (bif.mGrnt_ == 4'b1111) gaps++;
            else begin
                for (int i = 0; i < 4; i++)
                    if (!bif.mGrnt_[i] && (obs.size() == 0 || obs[$] != i)) obs.push_back(i);
            end
        end
        chk("order_len", (obs.size() >= 5), 1'b1);
        for (int k = 0; k < 5 && k < obs.size(); k++) chk("order", obs[k], exp_order[k]);
        chk("no_dead_cycle", gaps, 0);

        // Master 2 alone: grant, hold, release to idle.
        do_reset(4'b1111);
        repeat (9) drive(4'b1111, 4'b1111, 4'b1111);
        drive(4'b1011, 4'b1011, 4'b1011);
        chk("m2_grnt", bif.mGrnt_, 4'b1011);
        chk("m2_busy", bif.busy, 1'b1);
        chk("m2_sas", bif.sAs_, 1'b0);
        repeat (9) drive(4'b1011, 4'b1011, 4'b1011);
        drive(4'b1111, 4'b1111, 4'b1111);
        chk("m2_rel_grnt", bif.mGrnt_, 4'b1111);
        chk("m2_rel_busy", bif.busy, 1'b0);
        chk("m2_rel_sas", bif.sAs_, 1'b1);
        chk("m2_rel_owner", bif.owner, 2'd2);

        // Owner 1 releases with 0 and 3 waiting: scan 2,3,0 picks 3.
        do_reset(4'b1111);
        drive(4'b1101, 4'b1111, 4'b1111);
        chk("o1_grnt", bif.mGrnt_, 4'b1101);
        drive(4'b0100, 4'b1101, 4'b1111);
        drive(4'b0100, 4'b1101, 4'b1111);
        drive(4'b0110, 4'b1111, 4'b1111);
        chk("o1_handover", bif.mGrnt_, 4'b0111);
        chk("o1_new_owner", bif.owner, 2'd3);

        // Async reset mid-write by master 0.
        do_reset(4'b1111);
        drive(4'b1110, 4'b1111, 4'b1111);
        drive(4'b1110, 4'b1110, 4'b1110);
        drive(4'b1110, 4'b1110, 4'b1110);
        chk("pre_rst_sas", bif.sAs_, 1'b0);
        set_inputs(4'b1010, 4'b1110, 4'b1110);
        #2 reset = 1'b1;
        #1;
        chk("arst_grnt", bif.mGrnt_, 4'b1111);
        chk("arst_sas", bif.sAs_, 1'b1);
        chk("arst_busy", bif.busy, 1'b0);
        #1 reset = 1'b0;
        model_reset();
        model_step();
        exp_q.push_back(model_out());
        @(negedge clk);
        chk("post_rst_grnt", bif.mGrnt_, 4'b1110);

        // Hold limit: master 0 keeps requesting with a pulsing strobe while master 1 waits.
        do_reset(4'b1111);
        drive(4'b1110, 4'b1111, 4'b1111);
        bad     = 0;
        first_k = -1;
        for (int k = 0; k < 15; k++) begin
            as = {3'b111, (k % 3 == 2)};
            drive(4'b1100, as, 4'b1111);
            if (bif.mGrnt_ != 4'b1110) bad++;
            if (bif.mGrnt_ == 4'b1101 && first_k < 0) first_k = k;
        end
`ifdef ARB_HOLD_LIMIT_EN
        chk("hold_switch_cycle", first_k, 5);
`else
        chk("hold_keep", bad, 0);
`endif

        // Randomized traffic: requests toggle sparsely so ownership persists across cycles.
        do_reset(4'b1111);
        rq = 4'b1111;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < 4; i++)
                if ($urandom_range(3) == 0) rq[i] = ~rq[i];
            drive(rq, 4'($urandom), 4'($urandom));
        end

        @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_master_arbiter.md
Name: bus_master_arbiter

Overview:
- Shares the single system bus between 4 bus masters.
- Round-robin arbitration with registered, active-low grants.
- Steers the owning master's address/strobe/write data onto the shared bus, which feeds the address decoder and slave read-back mux.
- Ownership is held until the owner drops its request; an optional hold limit forces rotation between transactions.

Parameters:
- HOLD_MAX, 16, max consecutive cycles one master keeps the bus while others wait (used only with ARB_HOLD_LIMIT_EN).
- HOLD_CNT_W, 5, width of the hold counter; must satisfy 2^HOLD_CNT_W > HOLD_MAX.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- mReq_  in  4  per-master bus request, active low, bit i = master i
- mAddr  in  4*30  packed master word addresses, master i at [30*i+29:30*i]
- mAs_  in  4  per-master address strobe, active low
- mRw  in  4  per-master read/write select (READ=1, WRITE=0)
- mWrData  in  4*32  packed master write data, master i at [32*i+31:32*i]
- mGrnt_  out  4  per-master grant, active low, registered, one-cold or all-high
- sAddr  out  30  shared bus address
- sAs_  out  1  shared bus address strobe, active low
- sRw  out  1  shared bus read/write
- sWrData  out  32  shared bus write data
- owner  out  2  index of current/last owner (debug/observability)
- busy  out  1  high while some master holds a grant

Behaviour:
- Reset (async, active-high):
  - mGrnt_=4'b1111, busy=0, owner=2'd3 (so master 0 has first priority).
  - Hold counter=0, FSM=IDLE.
  - Reset asserted mid-transaction drops all grants immediately.
- FSM has two states: IDLE and GRANT.
  - IDLE: if any mReq_ bit is low, scan from owner+1 modulo 4.
    - The first requester found becomes owner; move to GRANT.
    - Its mGrnt_ bit goes low on the next edge (1-cycle request-to-grant latency).
  - GRANT, owner request still low: keep owner and grant.
  - GRANT, owner request high: rearbitrate in the same cycle, scanning from owner+1.
    - If another request is pending, the grant passes to it on the next edge. There is no dead cycle, and the old grant deasserts on that same edge.
    - If no request is pending, go to IDLE with mGrnt_=4'b1111. owner keeps the last value for priority.
- Other rules:
  - Simultaneous requests: round-robin order from owner+1 decides. An owner re-requesting after release loses to any waiting master.
  - At most one mGrnt_ bit is low in any cycle.
  - busy = ~&mGrnt_, registered with the grants.
- Shared-bus mux (combinational from registered owner/state):
  - In GRANT: sAddr/sAs_/sRw/sWrData = the owner's fields.
  - In IDLE: sAddr=0, sAs_=1, sRw=READ, sWrData=0.
- Masters must not drive mAs_ low without their grant; the arbiter ignores non-owner strobes.

Optional Feature:
- Macro: ARB_HOLD_LIMIT_EN.
- Defined:
  - Hold counter increments every GRANT cycle while any non-owner request is low. It clears on owner change, or when no other request is pending.
  - When counter >= HOLD_MAX and the owner's mAs_ is high (between transactions), ownership is forced to the next round-robin requester on the next edge. This happens even though the owner's request is still low.
  - The counter saturates at HOLD_MAX.
- Not defined: no counter logic; ownership changes only on release.

Decomposition:
- Shared package/include holds:
  - bus width macros (WORD_ADDR_W=30, WORD_DATA_W=32);
  - master count 4 and owner index width 2;
  - READ/WRITE encodings and ENABLE_/DISABLE_ levels;
  - FSM state encodings ARB_IDLE/ARB_GRANT.
- One natural sub-module: rr_pick4 (combinational). Inputs: request vector and last owner. Outputs: next index and a found flag.

Test Plan:
- Reset with mReq_=4'b0000 → after reset release: mGrnt_=4'b1110 one cycle later, owner=0, sAddr=mAddr[29:0].
- Master 2 alone requests at cycle 10 → mGrnt_=4'b1011 at cycle 11. Master 2 releases at cycle 20 → mGrnt_=4'b1111 and busy=0 at cycle 21, sAs_=1.
- All request, each releasing 3 cycles after its grant → grant order 0,1,2,3,0, with no cycle where all grants are high between handovers.
- Owner 1 holds, masters 0 and 3 waiting; owner 1 releases → master 3 granted next cycle (scan 2,3,0).
- Async reset pulse mid-write by master 0 → mGrnt_=4'b1111 and sAs_=1 before the next clock edge; first post-reset grant goes to the lowest requesting index.
- With ARB_HOLD_LIMIT_EN and HOLD_MAX=4: master 0 holds the request with mAs_ pulsing, master 1 waiting → grant moves to master 1 after 4 contended cycles, at the first cycle with mAs_[0]=1. Without the macro, master 0 keeps the bus indefinitely.
